// File: rtl/debug_step_controller_pkg.sv
// Shared constants for the debug step controller: host command codes,
// controller state encodings and the sequencer phase numbering.
package debug_step_controller_pkg;

  localparam logic [2:0] DBG_CMD_NOP     = 3'd0;
  localparam logic [2:0] DBG_CMD_STOP    = 3'd1;
  localparam logic [2:0] DBG_CMD_RUN     = 3'd2;
  localparam logic [2:0] DBG_CMD_STEP    = 3'd3;
  localparam logic [2:0] DBG_CMD_BP_SET  = 3'd4;
  localparam logic [2:0] DBG_CMD_BP_CLR  = 3'd5;
  localparam logic [2:0] DBG_CMD_CLR_ERR = 3'd6;

  typedef enum logic [2:0] {
    RUNNING   = 3'd0,
    STOP_WAIT = 3'd1,
    HALTED_S  = 3'd2,
    REQ_HI    = 3'd3,
    REQ_LO    = 3'd4
  } dbg_state_e;

  // Phase numbering of the sequencer on the far side of the debug interface.
  localparam logic [2:0] PHI_FETCH  = 3'd0;
  localparam logic [2:0] PHI_DECODE = 3'd1;
  localparam logic [2:0] PHI_EXEC   = 3'd2;
  localparam logic [2:0] PHI_COMMIT = 3'd3;
  localparam logic [2:0] PHI_DEBUG  = 3'd4;

  // States in which the controller waits on the sequencer and can time out.
  function automatic logic is_wait_state(input dbg_state_e s);
    return (s == STOP_WAIT) || (s == REQ_HI) || (s == REQ_LO);
  endfunction

endpackage

// File: rtl/dbg_timeout_counter.sv
// Cycle counter for sequencer responses; tc_o flags the last allowed
// waiting cycle so the controller can give up on the following edge.
module dbg_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  assign tc_o = en_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !tc_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_step_controller.sv
// Debug-side initiator for the phase sequencer: stop/run control, breakpoint
// on commit, four-phase single-step handshake and hung-sequencer timeout.
module debug_step_controller
  import debug_step_controller_pkg::*;
#(
  parameter bit START_STOPPED  = 1'b1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CMD_VALID,
  input  logic [2:0]       CMD,
  input  logic [15:0]      CMD_ARG,
  output logic             CMD_READY,
  input  logic [15:0]      PC,
  input  logic             COMMIT,
  input  logic             STOPPED,
  input  logic             DEBUG_ACTIVE,
  input  logic             DEBUG_STEP_ACK,
  output logic             DEBUG_STOPX,
  output logic             DEBUG_STEP_REQ,
  output logic             HALTED,
  output logic             BP_HIT,
  output logic             STEP_DONE,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] STEPS_LEFT,
  output logic [2:0]       DBG_STATE
);

  dbg_state_e       state_q;
  logic             stopx_q, req_q, halted_q, bp_hit_q, step_done_q, tmo_err_q;
  logic [CNT_W-1:0] steps_q;
  logic             bp_en_q;
  logic [15:0]      bp_addr_q;

  logic             cmd_acc, bp_match, wait_done, tmo_en, tmo_clr, tmo_tc;
  logic [CNT_W-1:0] step_load;

  // Host port: a command transfers on any edge where CMD_VALID && CMD_READY;
  // the host holds CMD/CMD_ARG stable while CMD_VALID is high and READY is low.
  assign CMD_READY = (state_q == RUNNING) || (state_q == HALTED_S);
  assign cmd_acc   = CMD_VALID && CMD_READY;
  assign bp_match  = bp_en_q && COMMIT && (PC == bp_addr_q);
  assign step_load = (CMD_ARG == 16'd0) ? CNT_W'(1) : CNT_W'(CMD_ARG);

  always_comb begin
    wait_done = 1'b0;
    case (state_q)
      STOP_WAIT: wait_done = STOPPED && DEBUG_ACTIVE;
      REQ_HI:    wait_done = req_q && DEBUG_STEP_ACK;
      REQ_LO:    wait_done = !DEBUG_STEP_ACK;
      default:   wait_done = 1'b0;
    endcase
  end

  assign tmo_en  = is_wait_state(state_q);
  assign tmo_clr = !tmo_en || wait_done;

  dbg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (CLK),
    .rst_ni(RESETN),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= START_STOPPED ? STOP_WAIT : RUNNING;
      stopx_q     <= START_STOPPED;
      req_q       <= 1'b0;
      halted_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
      tmo_err_q   <= 1'b0;
      steps_q     <= '0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
    end else begin
      step_done_q <= 1'b0;
      if (cmd_acc) begin
        case (CMD)
          DBG_CMD_BP_SET:  begin bp_en_q <= 1'b1; bp_addr_q <= CMD_ARG; end
          DBG_CMD_BP_CLR:  bp_en_q   <= 1'b0;
          DBG_CMD_CLR_ERR: tmo_err_q <= 1'b0;
          default: ;
        endcase
      end
      // A late response still wins over the timeout on the same edge.
      if (tmo_tc && !wait_done) begin
        tmo_err_q <= 1'b1;
        req_q     <= 1'b0;
        steps_q   <= '0;
        halted_q  <= 1'b1;
        state_q   <= HALTED_S;
      end else begin
        case (state_q)
          RUNNING: begin
            stopx_q <= 1'b0;
            if (bp_match) begin
              stopx_q  <= 1'b1;
              bp_hit_q <= 1'b1;
              state_q  <= STOP_WAIT;
            end else if (cmd_acc && (CMD == DBG_CMD_STOP)) begin
              stopx_q <= 1'b1;
              state_q <= STOP_WAIT;
            end
          end
          STOP_WAIT: begin
            if (wait_done) begin
              halted_q <= 1'b1;
              state_q  <= HALTED_S;
            end
          end
          HALTED_S: begin
            if (cmd_acc && (CMD == DBG_CMD_RUN)) begin
              stopx_q  <= 1'b0;
              halted_q <= 1'b0;
              bp_hit_q <= 1'b0;
              state_q  <= RUNNING;
            end else if (cmd_acc && (CMD == DBG_CMD_STEP)) begin
              steps_q  <= step_load;
              bp_hit_q <= 1'b0;
              halted_q <= 1'b0;
              state_q  <= REQ_HI;
            end
          end
          REQ_HI: begin
            // REQ only rises with ACK low, so a lingering ACK cannot double-step.
            if (wait_done) begin
              req_q   <= 1'b0;
              steps_q <= steps_q - 1'b1;
              state_q <= REQ_LO;
            end else if (!DEBUG_STEP_ACK) begin
              req_q <= 1'b1;
            end
          end
          REQ_LO: begin
            if (wait_done) begin
              if (steps_q != '0) begin
                state_q <= REQ_HI;
              end else begin
                step_done_q <= 1'b1;
                halted_q    <= 1'b1;
                state_q     <= HALTED_S;
              end
            end
          end
          default: begin
            req_q   <= 1'b0;
            stopx_q <= 1'b1;
            state_q <= STOP_WAIT;
          end
        endcase
      end
    end
  end

  assign DEBUG_STOPX    = stopx_q;
  assign DEBUG_STEP_REQ = req_q;
  assign HALTED         = halted_q;
  assign BP_HIT         = bp_hit_q;
  assign STEP_DONE      = step_done_q;
  assign TIMEOUT_ERR    = tmo_err_q;
  assign STEPS_LEFT     = steps_q;
  assign DBG_STATE      = state_q;

endmodule
